// File: rtl/truth_table_reader.sv
// truth_table_reader: sweeps all 128 minterms of a 7-input function, captures
// its output serially and returns the truth table and on-set count.
// Optional macro SELF_DUAL_CHECK_EN adds the self_dual output.
module truth_table_reader #(
    parameter int FN_LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         busy,
    output logic [6:0]   x_out,
    input  logic         fn_in,
    output logic [127:0] tt,
    output logic [7:0]   ones_cnt,
    output logic         tt_valid,
`ifdef SELF_DUAL_CHECK_EN
    output logic         self_dual,
`endif
    input  logic         tt_ready
);

    typedef enum logic [1:0] {IDLE, SWEEP, FLUSH, DONE} state_t;

    state_t                      state_q;
    logic                        busy_q;
    logic [6:0]                  x_out_q;
    logic                        xv_q;       // x_out currently carries a swept minterm
    logic [FN_LATENCY-1:0]       vld_pipe_q;
    logic [FN_LATENCY-1:0][6:0]  tag_pipe_q;
    logic [127:0]                tt_q;
    logic [7:0]                  ones_q;
    logic                        tt_valid_q;

    logic       cap;
    logic [6:0] cap_tag;
    logic       cap_last;

    assign cap      = vld_pipe_q[FN_LATENCY-1];
    assign cap_tag  = tag_pipe_q[FN_LATENCY-1];
    assign cap_last = cap && (cap_tag == 7'd127);

`ifdef SELF_DUAL_CHECK_EN
    logic         sd_q;
    logic         sd_d;
    logic [127:0] tt_cap;

    // Self-duality of the table as it will look once the current bit lands
    always_comb begin
        tt_cap = tt_q;
        if (cap) tt_cap[cap_tag] = fn_in;
        sd_d = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (tt_cap[i] == tt_cap[127-i]) sd_d = 1'b0;
        end
    end

    assign self_dual = sd_q;
`endif

    // Sweep FSM, tag pipe and capture into the truth table
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            x_out_q    <= '0;
            xv_q       <= 1'b0;
            vld_pipe_q <= '0;
            tag_pipe_q <= '0;
            tt_q       <= '0;
            ones_q     <= '0;
            tt_valid_q <= 1'b0;
`ifdef SELF_DUAL_CHECK_EN
            sd_q       <= 1'b0;
`endif
        end else begin
            // Tags follow x_out so each fn_in sample knows which minterm it is
            vld_pipe_q[0] <= xv_q;
            tag_pipe_q[0] <= x_out_q;
            for (int k = 1; k < FN_LATENCY; k++) begin
                vld_pipe_q[k] <= vld_pipe_q[k-1];
                tag_pipe_q[k] <= tag_pipe_q[k-1];
            end

            if (cap) begin
                tt_q[cap_tag] <= fn_in;
                ones_q        <= ones_q + {7'd0, fn_in};
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= SWEEP;
                        busy_q     <= 1'b1;
                        x_out_q    <= '0;
                        xv_q       <= 1'b1;
                        tt_q       <= '0;
                        ones_q     <= '0;
                        tt_valid_q <= 1'b0;
`ifdef SELF_DUAL_CHECK_EN
                        sd_q       <= 1'b0;
`endif
                    end
                end
                SWEEP: begin
                    // x_out parks at 127 once the last minterm is issued
                    if (xv_q) begin
                        if (x_out_q == 7'd127) begin
                            xv_q <= 1'b0;
                            if (FN_LATENCY > 1) state_q <= FLUSH;
                        end else begin
                            x_out_q <= x_out_q + 7'd1;
                        end
                    end
                end
                FLUSH: ;
                DONE: begin
                    if (tt_valid_q && tt_ready) begin
                        tt_valid_q <= 1'b0;
                        state_q    <= IDLE;
                        x_out_q    <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Landing the final minterm completes the table
            if (cap_last) begin
                state_q    <= DONE;
                busy_q     <= 1'b0;
                tt_valid_q <= 1'b1;
`ifdef SELF_DUAL_CHECK_EN
                sd_q       <= sd_d;
`endif
            end
        end
    end

    assign busy     = busy_q;
    assign x_out    = x_out_q;
    assign tt       = tt_q;
    assign ones_cnt = ones_q;
    assign tt_valid = tt_valid_q;

endmodule

// File: tb/tb_truth_table_reader.sv
// Bench for truth_table_reader: two instances (FN_LATENCY 1 and 3) driven by a
// behavioural function model behind a latency delay line.
module tb_truth_table_reader;

    logic clk = 1'b0;
    logic rst, start, tt_ready;
    always #5 clk = ~clk;

    logic         busy1, busy3, v1, v3, fn1, fn3;
    logic [6:0]   x1, x3;
    logic [127:0] tt1, tt3;
    logic [7:0]   oc1, oc3;
`ifdef SELF_DUAL_CHECK_EN
    logic         sd1, sd3;
`endif

    truth_table_reader #(.FN_LATENCY(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .busy(busy1), .x_out(x1),
        .fn_in(fn1), .tt(tt1), .ones_cnt(oc1), .tt_valid(v1),
`ifdef SELF_DUAL_CHECK_EN
        .self_dual(sd1),
`endif
        .tt_ready(tt_ready));

    truth_table_reader #(.FN_LATENCY(3)) u3 (
        .clk(clk), .rst(rst), .start(start), .busy(busy3), .x_out(x3),
        .fn_in(fn3), .tt(tt3), .ones_cnt(oc3), .tt_valid(v3),
`ifdef SELF_DUAL_CHECK_EN
        .self_dual(sd3),
`endif
        .tt_ready(tt_ready));

    int           errors = 0;
    int           checks = 0;
    int           mode = 0;
    logic [127:0] rand_tbl;

    // Function under test: 0 x0, 1 const 0, 2 const 1, 3 maj(x0,x1,x2), 4 table
    function automatic logic f(input int m, input logic [6:0] x);
        case (m)
            0:       return x[0];
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
            default: return rand_tbl[x];
        endcase
    endfunction

    logic       d1;
    logic [2:0] d3;
    always @(posedge clk) begin
        d1 <= f(mode, x1);
        d3 <= {d3[1:0], f(mode, x3)};
    end
    assign fn1 = d1;
    assign fn3 = d3[2];

    // Reference model: table, popcount and self-duality computed from f itself
    task automatic model(output logic [127:0] et, output int eo, output logic esd);
        et = '0; eo = 0; esd = 1'b1;
        for (int i = 0; i < 128; i++) begin
            et[i] = f(mode, 7'(i));
            eo += int'(et[i]);
        end
        for (int i = 0; i < 128; i++) if (f(mode, 7'(i)) == f(mode, 7'(127 - i))) esd = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Cycle 1 is the cycle after the start cycle
    task automatic wait_done(output int t1, output int t3);
        int n = 0;
        t1 = -1; t3 = -1;
        while ((t1 < 0 || t3 < 0) && n < 400) begin
            @(negedge clk); n++;
            if (t1 < 0 && v1) t1 = n;
            if (t3 < 0 && v3) t3 = n;
        end
        checks++;
        if (t1 < 0 || t3 < 0) begin
            errors++;
            $display("FAIL wait_done: tt_valid timeout t1=%0d t3=%0d", t1, t3);
        end
    endtask

    task automatic check_res(string nm, logic [127:0] et, int eo, logic esd,
                             int t1, int t3, bit chk_t);
        checks += 4;
        if (tt1 !== et) begin errors++; $display("FAIL %s tt1 got %h want %h", nm, tt1, et); end
        if (tt3 !== et) begin errors++; $display("FAIL %s tt3 got %h want %h", nm, tt3, et); end
        if (oc1 !== 8'(eo)) begin errors++; $display("FAIL %s ones1 got %0d want %0d", nm, oc1, eo); end
        if (oc3 !== 8'(eo)) begin errors++; $display("FAIL %s ones3 got %0d want %0d", nm, oc3, eo); end
        if (chk_t) begin
            checks += 2;
            if (t1 != 130) begin errors++; $display("FAIL %s lat1 got %0d want 130", nm, t1); end
            if (t3 != 132) begin errors++; $display("FAIL %s lat3 got %0d want 132", nm, t3); end
        end
`ifdef SELF_DUAL_CHECK_EN
        checks += 2;
        if (sd1 !== esd) begin errors++; $display("FAIL %s sd1 got %b want %b", nm, sd1, esd); end
        if (sd3 !== esd) begin errors++; $display("FAIL %s sd3 got %b want %b", nm, sd3, esd); end
`else
        if (esd === 1'bx) $display("self-dual model undefined");
`endif
    endtask

    // Handshake; optionally start again on the very next edge
    task automatic accept(bit restart);
        @(negedge clk); tt_ready = 1'b1;
        @(posedge clk); #1 tt_ready = 1'b0;
        if (restart) begin
            start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            @(negedge clk);
            checks++;
            if (v1 !== 1'b0 || v3 !== 1'b0 || busy1 !== 1'b1 || busy3 !== 1'b1) begin
                errors++;
                $display("FAIL b2b_restart v=%b%b busy=%b%b want v=00 busy=11", v1, v3, busy1, busy3);
            end
        end else begin
            @(negedge clk);
            checks++;
            if (v1 !== 1'b0 || v3 !== 1'b0 || busy1 !== 1'b0 || busy3 !== 1'b0 || x1 !== 7'd0) begin
                errors++;
                $display("FAIL accept v=%b%b busy=%b%b x=%0d want all 0", v1, v3, busy1, busy3, x1);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; tt_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy1, busy3, v1, v3} !== 4'b0 || x1 !== 7'd0 || x3 !== 7'd0 ||
            tt1 !== 128'd0 || tt3 !== 128'd0 || oc1 !== 8'd0 || oc3 !== 8'd0) begin
            errors++;
            $display("FAIL reset busy=%b%b v=%b%b x=%0d/%0d oc=%0d/%0d want 0", busy1, busy3, v1, v3, x1, x3, oc1, oc3);
        end
        rst = 1'b0;
    endtask

    task automatic test_x0();
        int t1, t3;
        mode = 0;
        do_start();
        @(negedge clk);
        checks++;
        if (busy1 !== 1'b1 || x1 !== 7'd0) begin
            errors++; $display("FAIL sweep_first busy=%b x=%0d want 1/0", busy1, x1);
        end
        @(negedge clk);
        checks++;
        if (x1 !== 7'd1 || x3 !== 7'd1) begin
            errors++; $display("FAIL sweep_step x=%0d/%0d want 1", x1, x3);
        end
        wait_done(t1, t3);
        t1 += 2; t3 += 2;  // two negedges already consumed above
        check_res("x0", {32{4'hA}}, 64, 1'b1, t1, t3, 1'b1);
        accept(1'b0);
    endtask

    task automatic test_const();
        int t1, t3;
        mode = 1; do_start(); wait_done(t1, t3);
        check_res("zero", 128'd0, 0, 1'b0, t1, t3, 1'b1);
        accept(1'b0);
        mode = 2; do_start(); wait_done(t1, t3);
        check_res("one", {128{1'b1}}, 128, 1'b0, t1, t3, 1'b1);
        accept(1'b0);
    endtask

    task automatic test_backpressure();
        int t1, t3;
        logic [127:0] h1, h3;
        logic [7:0]   o1, o3;
        bit           bad = 0;
        mode = 3; do_start(); wait_done(t1, t3);
        check_res("maj", {16{8'hE8}}, 64, 1'b1, t1, t3, 1'b1);
        h1 = tt1; h3 = tt3; o1 = oc1; o3 = oc3;
        for (int c = 0; c < 10; c++) begin
            start = (c == 4);
            @(negedge clk);
            if (!v1 || !v3 || tt1 !== h1 || tt3 !== h3 || oc1 !== o1 || oc3 !== o3 || busy1 || busy3)
                bad = 1;
        end
        start = 1'b0;
        checks++;
        if (bad) begin errors++; $display("FAIL backpressure_hold v=%b%b busy=%b%b want v=11 busy=00 stable", v1, v3, busy1, busy3); end
        accept(1'b0);
        checks++;
        if (tt1 !== {16{8'hE8}} || oc1 !== 8'd64) begin
            errors++; $display("FAIL hold_after_accept tt=%h oc=%0d want e8.. 64", tt1, oc1);
        end
    endtask

    task automatic test_midreset();
        int n = 0;
        int t1, t3;
        mode = 4; rand_tbl = {$urandom, $urandom, $urandom, $urandom};
        do_start();
        while (x1 !== 7'd50 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (x1 !== 7'd50) begin errors++; $display("FAIL midreset_reach x=%0d want 50", x1); end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if (busy1 || busy3 || x1 !== 7'd0 || x3 !== 7'd0 || tt1 !== 128'd0 || tt3 !== 128'd0 || v1 || v3 || oc1 || oc3) begin
            errors++; $display("FAIL midreset busy=%b%b x=%0d/%0d v=%b%b want 0", busy1, busy3, x1, x3, v1, v3);
        end
        rst = 1'b0;
        begin
            logic [127:0] et; int eo; logic esd;
            model(et, eo, esd);
            do_start(); wait_done(t1, t3);
            check_res("after_rst", et, eo, esd, t1, t3, 1'b1);
        end
        accept(1'b0);
    endtask

    task automatic test_random_b2b();
        int t1, t3;
        logic [127:0] et; int eo; logic esd;
        mode = 4;
        rand_tbl = {$urandom, $urandom, $urandom, $urandom};
        do_start();
        for (int it = 0; it < 100; it++) begin
            wait_done(t1, t3);
            model(et, eo, esd);
            check_res("random", et, eo, esd, t1, t3, 1'b0);
            // Heavily biased tables on some iterations stress stale-bit clearing
            case (it % 4)
                0:       rand_tbl = {$urandom, $urandom, $urandom, $urandom};
                1:       rand_tbl = {$urandom, $urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom, $urandom};
                2:       rand_tbl = {$urandom, $urandom, $urandom, $urandom} | {$urandom, $urandom, $urandom, $urandom};
                default: rand_tbl = ~tt1;
            endcase
            accept(it != 99);
        end
    endtask

    initial begin
        test_reset();
        test_x0();
        test_const();
        test_backpressure();
        test_midreset();
        test_random_b2b();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
